// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage for the single-cycle LEGv8 datapath.
// Holds the 64-bit PC, keeps at most one instruction-memory read in flight,
// buffers returned words in a small circular queue toward decode, and applies
// taken-branch redirects (flush the queue, drop stale responses).
// Optional feature macro: FETCH_BL_EN adds the link_pc output (br_pc+4
// captured on unconditional redirects, used for the BL write to X30).
module instr_fetch #(
    parameter int          QDEPTH   = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
`ifdef FETCH_BL_EN
    output logic [63:0] link_pc,
`endif
    input  logic        redirect,
    input  logic        br_uncond,
    input  logic [63:0] br_pc,
    input  logic [25:0] Imm26,
    input  logic [18:0] Imm19
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(QDEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [63:0]   pc;

    logic [31:0]   q_instr [QDEPTH];
    logic [63:0]   q_pc    [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          q_full;

    logic          push;
    logic          pop;

    logic [63:0]   offset_word;
    logic [63:0]   br_target;

    // Branch target: sign-extend the selected word offset, scale to bytes, add.
    always_comb begin
        offset_word = '0;
        if (br_uncond) begin
            offset_word = {{38{Imm26[25]}}, Imm26};
        end else begin
            offset_word = {{45{Imm19[18]}}, Imm19};
        end
        br_target = br_pc + (offset_word << 2);
    end

    // Queue bookkeeping; a redirect overrides both push and pop in its cycle.
    always_comb begin
        q_full = (count == FULL_COUNT);
        push   = (state == WAIT) && imem_rvalid && !redirect;
        pop    = (count != '0) && instr_ready && !redirect;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DRAIN swallows exactly one response before refetching.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (imem_req) begin
                    state_next = redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = FETCH;
                end else if (redirect) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Outputs: request whenever fetching with room in the queue; head is zero when empty.
    always_comb begin
        imem_req    = (state == FETCH) && !q_full;
        imem_addr   = pc;
        instr_valid = (count != '0);
        instr       = '0;
        instr_pc    = '0;
        if (count != '0) begin
            instr    = q_instr[rd_ptr];
            instr_pc = q_pc[rd_ptr];
        end
    end

    // Program counter: redirect wins, otherwise advance one word per accepted response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= br_target;
        end else if (push) begin
            pc <= pc + 64'd4;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // Queue storage; contents are only observed through a valid head, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= pc;
        end
    end

`ifdef FETCH_BL_EN
    // Link register: return address of the most recent unconditional redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            link_pc <= '0;
        end else if (redirect && br_uncond) begin
            link_pc <= br_pc + 64'd4;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch. A responder models the
// instruction memory, a behavioural model of the fetch stage predicts every
// output each cycle, and directed scenarios pin literal values.
// Build with FETCH_BL_EN defined to also exercise link_pc.
module tb_instr_fetch;

    localparam int          QDEPTH   = 2;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic        br_uncond;
    logic [63:0] br_pc;
    logic [25:0] imm26;
    logic [18:0] imm19;
`ifdef FETCH_BL_EN
    logic [63:0] link_pc;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    int stray_req = 0;

    logic [63:0] consumed_pc [$];
    logic [31:0] consumed_ins [$];

    instr_fetch #(
        .QDEPTH  (QDEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
`ifdef FETCH_BL_EN
        .link_pc    (link_pc),
`endif
        .redirect   (redirect),
        .br_uncond  (br_uncond),
        .br_pc      (br_pc),
        .Imm26      (imm26),
        .Imm19      (imm19)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed hash of the byte address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] h;
        h = a * 64'h9E37_79B9_7F4A_7C15;
        return h[51:20];
    endfunction

    // Branch target computed with signed integer arithmetic.
    function automatic logic [63:0] branch_target(input logic [63:0] pc, input logic unc,
                                                  input logic [25:0] i26, input logic [18:0] i19);
        longint off;
        off = unc ? longint'($signed(i26)) : longint'($signed(i19));
        return pc + 64'(off * 4);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic expect_consumed(input string name, input int idx, input logic [63:0] pc_exp,
                                   input logic [31:0] ins_exp);
        if (consumed_pc.size() > idx) begin
            checkOutput({name, "_pc"}, consumed_pc[idx], pc_exp);
            checkOutput({name, "_instr"}, 64'(consumed_ins[idx]), 64'(ins_exp));
        end else begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s actual=missing expected=%h", name, pc_exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic unc,
                                 input logic [63:0] bpc, input logic [25:0] i26, input logic [18:0] i19);
        instr_ready = rdy;
        redirect    = redir;
        br_uncond   = unc;
        br_pc       = bpc;
        imm26       = i26;
        imm19       = i19;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Memory responder: accepts a request at the clock edge, answers after mem_lat cycles.
    initial begin : mem_responder
        logic        req_now;
        logic [63:0] addr_now;
        logic        rst_seen;
        logic        pending;
        int          countdown;
        logic [63:0] paddr;
        int          stray_done;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pending     = 1'b0;
        countdown   = 0;
        paddr       = '0;
        stray_done  = 0;
        forever begin
            @(negedge clk);
            req_now  = imem_req;
            addr_now = imem_addr;
            rst_seen = reset_n;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (!rst_seen) begin
                pending = 1'b0;
            end else begin
                if (req_now) begin
                    pending   = 1'b1;
                    paddr     = addr_now;
                    countdown = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
                end
                if (pending) begin
                    countdown--;
                    if (countdown == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(paddr);
                        pending     = 1'b0;
                    end
                end
            end
            if (stray_req != stray_done) begin
                stray_done  = stray_req;
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hBAD0_BAD0;
            end
        end
    end

    // Behavioural model and per-cycle comparison against the DUT.
    initial begin : compare_proc
        typedef struct packed {
            logic [31:0] ins;
            logic [63:0] pc;
        } entry_t;
        entry_t      mq [$];
        logic [63:0] m_pc;
        logic [63:0] m_link;
        bit          m_busy;
        bit          m_drop;
        bit          exp_req;
        m_pc   = RESET_PC;
        m_link = '0;
        m_busy = 1'b0;
        m_drop = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mq.delete();
                m_pc   = RESET_PC;
                m_link = '0;
                m_busy = 1'b0;
                m_drop = 1'b0;
                checkOutput("rst_instr", 64'(instr), 64'h0);
                checkOutput("rst_instr_pc", instr_pc, 64'h0);
            end
            exp_req = !m_busy && (mq.size() < QDEPTH);
            checkOutput("imem_req", 64'(imem_req), 64'(exp_req));
            if (exp_req) checkOutput("imem_addr", imem_addr, m_pc);
            checkOutput("instr_valid", 64'(instr_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                checkOutput("instr", 64'(instr), 64'(mq[0].ins));
                checkOutput("instr_pc", instr_pc, mq[0].pc);
            end
`ifdef FETCH_BL_EN
            checkOutput("link_pc", link_pc, m_link);
`endif
            if (reset_n) begin
                if (instr_valid && instr_ready && !redirect) begin
                    consumed_pc.push_back(instr_pc);
                    consumed_ins.push_back(instr);
                end
                if (redirect) begin
                    mq.delete();
                    if (!m_busy) begin
                        if (exp_req) begin
                            m_busy = 1'b1;
                            m_drop = 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                    m_pc = branch_target(br_pc, br_uncond, imm26, imm19);
                    if (br_uncond) m_link = br_pc + 64'd4;
                end else begin
                    if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
                    if (!m_busy) begin
                        if (exp_req) begin
                            m_busy = 1'b1;
                            m_drop = 1'b0;
                        end
                    end else if (imem_rvalid) begin
                        if (!m_drop) begin
                            mq.push_back({imem_rdata, m_pc});
                            m_pc = m_pc + 64'd4;
                        end
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin : main_proc
        bit hit;
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        tick();
        tick();

        // Straight-line fetch with single-cycle memory.
        $display("[TB] sequential fetch");
        mem_lat = 1;
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        checkOutput("t1_first_req", 64'(imem_req), 64'h1);
        checkOutput("t1_first_addr", imem_addr, RESET_PC);
        checkOutput("t1_first_valid", 64'(instr_valid), 64'h0);
        consumed_pc.delete();
        consumed_ins.delete();
        repeat (10) tick();
        expect_consumed("t1_seq0", 0, 64'h0, mem_word(64'h0));
        expect_consumed("t1_seq1", 1, 64'h4, mem_word(64'h4));
        expect_consumed("t1_seq2", 2, 64'h8, mem_word(64'h8));
        expect_consumed("t1_seq3", 3, 64'hC, mem_word(64'hC));

        // Back-pressure fills the queue, then drains in order.
        $display("[TB] back-pressure");
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        do_reset();
        repeat (10) tick();
        checkOutput("t2_full_valid", 64'(instr_valid), 64'h1);
        checkOutput("t2_full_head", instr_pc, 64'h0);
        checkOutput("t2_full_req", 64'(imem_req), 64'h0);
        consumed_pc.delete();
        consumed_ins.delete();
        instr_ready = 1'b1;
        repeat (12) tick();
        expect_consumed("t2_seq0", 0, 64'h0, mem_word(64'h0));
        expect_consumed("t2_seq1", 1, 64'h4, mem_word(64'h4));
        expect_consumed("t2_seq2", 2, 64'h8, mem_word(64'h8));
        expect_consumed("t2_seq3", 3, 64'hC, mem_word(64'hC));

        // Unconditional redirect with a negative offset while idle and full.
        $display("[TB] B redirect");
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        do_reset();
        repeat (6) tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h40, 26'h3FF_FFFC, 19'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        checkOutput("t3_flush_valid", 64'(instr_valid), 64'h0);
        checkOutput("t3_req", 64'(imem_req), 64'h1);
        checkOutput("t3_addr", imem_addr, 64'h30);
`ifdef FETCH_BL_EN
        checkOutput("t3_link", link_pc, 64'h44);
`endif

        // Conditional redirect while a slow request is outstanding.
        $display("[TB] CBZ redirect in flight");
        mem_lat = 3;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        do_reset();
        tick();
        consumed_pc.delete();
        consumed_ins.delete();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h100, 26'h0, 19'h3);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        repeat (20) tick();
        expect_consumed("t4_first", 0, 64'h10C, mem_word(64'h10C));

        // Redirect coinciding with a response and a pop.
        $display("[TB] redirect with rvalid and ready");
        mem_lat = 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (imem_rvalid && instr_valid) begin
                hit = 1'b1;
                applyStimulus(1'b1, 1'b1, 1'b0, 64'h200, 26'h0, 19'h7FFFF);
            end
        end
        checkOutput("t5_found_overlap", 64'(hit), 64'h1);
        consumed_pc.delete();
        consumed_ins.delete();
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        checkOutput("t5_flush_valid", 64'(instr_valid), 64'h0);
        checkOutput("t5_req", 64'(imem_req), 64'h1);
        checkOutput("t5_addr", imem_addr, 64'h1FC);
        repeat (8) tick();
        expect_consumed("t5_first", 0, 64'h1FC, mem_word(64'h1FC));

        // Reset while waiting, then a late response right after release.
        $display("[TB] reset during WAIT");
        mem_lat = 3;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        do_reset();
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 64'(instr_valid), 64'h0);
        checkOutput("t6_rst_req", 64'(imem_req), 64'h1);
        checkOutput("t6_rst_addr", imem_addr, RESET_PC);
        @(negedge clk);
        stray_req++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        consumed_pc.delete();
        consumed_ins.delete();
        repeat (14) tick();
        expect_consumed("t6_first", 0, 64'h0, 32'h0);

        // Randomized traffic: random ready, latency, redirects and occasional resets.
        $display("[TB] random traffic");
        mem_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] rpc;
            rpc = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), 1'($urandom),
                          rpc, 26'($urandom), 19'($urandom));
            reset_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the single-cycle LEGv8 datapath. Holds the 64-bit PC and issues word reads to instruction memory with one request outstanding at a time. Buffers returned instructions in a small queue with a valid/ready handshake toward decode, which extracts Rd/Rn/Rm/Imm12/DAddr9/Imm16/SHAMT. Applies branch redirects (B, CBZ, B.cond) by computing the target, flushing the queue and dropping stale in-flight responses.

## Interface
- QDEPTH, 2: instruction queue entries (power of two, ≥2)
- RESET_PC, 64'h0: PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request; memory accepts it in the same cycle
- imem_addr  out  64  byte address of the request (always PC, word aligned)
- imem_rvalid  in  1  response valid; earliest the cycle after the request
- imem_rdata  in  32  instruction word
- instr_valid  out  1  queue head valid
- instr  out  32  queue head instruction
- instr_pc  out  64  PC of queue head instruction
- instr_ready  in  1  decode consumes the head when instr_valid & instr_ready
- redirect  in  1  taken-branch strobe, one cycle
- br_uncond  in  1  1: offset = Imm26 (B/BL); 0: offset = Imm19 (CBZ, B.cond)
- br_pc  in  64  PC of the branching instruction
- Imm26  in  26  signed word offset
- Imm19  in  19  signed word offset
- link_pc  out  64  br_pc+4 captured at redirect (only with FETCH_BL_EN)

## Operation
- States: FETCH, WAIT, DRAIN.
- FETCH: assert imem_req with imem_addr = PC when queue occupancy < QDEPTH, then go to WAIT. With the queue full, hold imem_req low and stay in FETCH.
- WAIT: on imem_rvalid, push {imem_rdata, PC} and set PC = PC+4, then go to FETCH.
- DRAIN: the next imem_rvalid is discarded, then go to FETCH. PC is not advanced.
- Redirect: target = br_pc + (SE(offset) << 2), mod 2^64.
  - Set PC = target and flush the queue (instr_valid = 0 next cycle).
  - From FETCH with imem_req high, or from WAIT without rvalid: go to DRAIN.
  - From WAIT with rvalid in the same cycle: drop the response and go to FETCH.
  - From DRAIN: stay in DRAIN with the new PC; an rvalid in that cycle counts as the drained response, then go to FETCH.
  - Otherwise go to FETCH.
- Redirect has priority over push and pop in the same cycle.
- Queue: circular, pointer wrap modulo QDEPTH. Simultaneous push and pop when full is legal (pop frees the slot); occupancy is unchanged.
- Offsets are sign-extended to 64 bits before the shift. No alignment check is made on the target.

## Timing
- Reset (async assert, sync release): PC = RESET_PC, state = FETCH, queue empty.
  - Outputs: imem_req = 1 combinationally from FETCH, imem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0, link_pc = 0.
- reset_n asserted mid-operation clears all state immediately. An outstanding response that arrives after release is ignored, because state is FETCH, not WAIT.
- Latency from imem_rvalid to instr_valid: 1 cycle.
- Latency from redirect to imem_req at the target:
  - Next cycle when nothing is in flight.
  - The cycle after the dropped rvalid otherwise.
- Throughput: one instruction per (memory latency + 1) cycles.

## Configuration
- FETCH_BL_EN defined: on redirect with br_uncond = 1, link_pc registers br_pc+4 and holds it until the next such redirect. This feeds the X30 write for BL.
- FETCH_BL_EN undefined: no link_pc port and no link register logic.

## Test plan
- Reset release with 1-cycle memory → instr_pc sequence 0, 4, 8, 12 at one instruction per 2 cycles; instr matches memory.
- instr_ready = 0 for 10 cycles → occupancy reaches QDEPTH, imem_req goes low, the head holds PC 0; ready = 1 resumes in order without loss or duplication.
- redirect with br_uncond = 1, br_pc = 0x40, Imm26 = -4 → next request at 0x30, queue flushed; link_pc = 0x44 when FETCH_BL_EN is defined.
- redirect with Imm19 = 3 while a request is outstanding (3-cycle memory) → stale response dropped, first new instr_pc = br_pc+12.
- redirect in the same cycle as imem_rvalid and instr_ready → nothing is pushed, the head is not double-consumed, instr_valid = 0 next cycle.
- reset_n pulsed low while in WAIT, then a late rvalid arrives → ignored; fetch restarts at RESET_PC.
